// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing and the per-entry record layout.
package rob_pkg;

   localparam int unsigned ROBID_W        = 4;
   localparam int unsigned DEPTH          = 2 ** ROBID_W;
   localparam int unsigned DATA_W         = 8;
   localparam int unsigned FLAG_TAKEN_BIT = 5;

   typedef struct packed {
      logic              busy;
      logic              done;
      logic [DATA_W-1:0] wbs;
      logic [DATA_W-1:0] flags;
      logic [DATA_W-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion-bus and retire signals of the reorder buffer.
interface reorder_buffer_if #(
   parameter int unsigned ROBID_W = rob_pkg::ROBID_W
);
   import rob_pkg::*;

   // Dispatch side
   logic                alloc_valid;
   logic [DATA_W-1:0]   alloc_wbs;
   logic                alloc_ready;
   logic [ROBID_W-1:0]  alloc_robid;

   // Completion bus
   logic                rob_transmit;
   logic [ROBID_W-1:0]  robid;
   logic [DATA_W-1:0]   flags;
   logic [DATA_W-1:0]   wbs;
   logic [DATA_W-1:0]   value;

   // Retire side
   logic                commit_valid;
   logic [ROBID_W-1:0]  commit_robid;
   logic [DATA_W-1:0]   commit_wbs;
   logic [DATA_W-1:0]   commit_flags;
   logic [DATA_W-1:0]   commit_value;
   logic                flush;
   logic [DATA_W-1:0]   redirect_pc;
   logic [ROBID_W:0]    count;
   logic                protocol_err;

   modport master (
      output alloc_valid, alloc_wbs, rob_transmit, robid, flags, wbs, value,
      input  alloc_ready, alloc_robid, commit_valid, commit_robid, commit_wbs,
             commit_flags, commit_value, flush, redirect_pc, count, protocol_err
   );

   modport slave (
      input  alloc_valid, alloc_wbs, rob_transmit, robid, flags, wbs, value,
      output alloc_ready, alloc_robid, commit_valid, commit_robid, commit_wbs,
             commit_flags, commit_value, flush, redirect_pc, count, protocol_err
   );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retire buffer: allocate at tail, out-of-order completion writes,
// one retire per cycle at head, full squash when a taken branch retires.
module reorder_buffer #(
   parameter int unsigned DEPTH   = rob_pkg::DEPTH,
   parameter int unsigned ROBID_W = rob_pkg::ROBID_W
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave rob
);
   import rob_pkg::*;

   localparam int unsigned      CNT_W   = ROBID_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   rob_entry_t         entries_q [DEPTH];
   rob_entry_t         entries_d [DEPTH];
   logic [ROBID_W-1:0] head_q, head_d;
   logic [ROBID_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               protocol_err_q, protocol_err_d;
   logic               commit_valid_q, commit_valid_d;
   logic [ROBID_W-1:0] commit_robid_q, commit_robid_d;
   logic [DATA_W-1:0]  commit_wbs_q, commit_wbs_d;
   logic [DATA_W-1:0]  commit_flags_q, commit_flags_d;
   logic [DATA_W-1:0]  commit_value_q, commit_value_d;
   logic               flush_q, flush_d;
   logic [DATA_W-1:0]  redirect_pc_q, redirect_pc_d;

   rob_entry_t head_e;
   rob_entry_t wr_e;
   logic       head_taken;
   logic       retire;
   logic       taken;
   logic       alloc_fire;

   assign head_e     = entries_q[head_q];
   assign wr_e       = entries_q[rob.robid];
   assign head_taken = head_e.busy && head_e.done && head_e.flags[FLAG_TAKEN_BIT];
   assign retire     = (count_q != '0) && head_e.busy && head_e.done;
   assign taken      = retire && head_e.flags[FLAG_TAKEN_BIT];

   // Block dispatch while a taken branch waits at head: its retire squashes everything.
   assign rob.alloc_ready = (count_q < DEPTH_C) && !head_taken;
   assign alloc_fire      = rob.alloc_valid && rob.alloc_ready;
   assign rob.alloc_robid = tail_q;

   always_comb begin
      entries_d      = entries_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      protocol_err_d = protocol_err_q;
      commit_valid_d = retire;
      commit_robid_d = commit_robid_q;
      commit_wbs_d   = commit_wbs_q;
      commit_flags_d = commit_flags_q;
      commit_value_d = commit_value_q;
      flush_d        = taken;
      redirect_pc_d  = redirect_pc_q;

      // Writes racing a flush target squashed work, so they are dropped without an error.
      if (rob.rob_transmit && !taken) begin
         if (wr_e.busy && !wr_e.done) begin
            entries_d[rob.robid].done  = 1'b1;
            entries_d[rob.robid].flags = rob.flags;
            entries_d[rob.robid].wbs   = rob.wbs;
            entries_d[rob.robid].value = rob.value;
         end else begin
            protocol_err_d = 1'b1;
         end
      end

      if (retire) begin
         commit_robid_d = head_q;
         commit_wbs_d   = head_e.wbs;
         commit_flags_d = head_e.flags;
         commit_value_d = head_e.value;
      end

      if (taken) begin
         entries_d     = '{default: '0};
         head_d        = '0;
         tail_d        = '0;
         count_d       = '0;
         redirect_pc_d = head_e.value;
      end else begin
         if (retire) begin
            entries_d[head_q] = '0;
            head_d            = head_q + ROBID_W'(1);
         end
         if (alloc_fire) begin
            entries_d[tail_q] = '{busy: 1'b1, done: 1'b0, wbs: rob.alloc_wbs,
                                  flags: '0, value: '0};
            tail_d            = tail_q + ROBID_W'(1);
         end
         count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         entries_q      <= '{default: '0};
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         protocol_err_q <= 1'b0;
         commit_valid_q <= 1'b0;
         commit_robid_q <= '0;
         commit_wbs_q   <= '0;
         commit_flags_q <= '0;
         commit_value_q <= '0;
         flush_q        <= 1'b0;
         redirect_pc_q  <= '0;
      end else begin
         entries_q      <= entries_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         protocol_err_q <= protocol_err_d;
         commit_valid_q <= commit_valid_d;
         commit_robid_q <= commit_robid_d;
         commit_wbs_q   <= commit_wbs_d;
         commit_flags_q <= commit_flags_d;
         commit_value_q <= commit_value_d;
         flush_q        <= flush_d;
         redirect_pc_q  <= redirect_pc_d;
      end
   end

   assign rob.count        = count_q;
   assign rob.protocol_err = protocol_err_q;
   assign rob.commit_valid = commit_valid_q;
   assign rob.commit_robid = commit_robid_q;
   assign rob.commit_wbs   = commit_wbs_q;
   assign rob.commit_flags = commit_flags_q;
   assign rob.commit_value = commit_value_q;
   assign rob.flush        = flush_q;
   assign rob.redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table, directed corner sequences, then
// random traffic against a queue-based reference model.
module tb_reorder_buffer;
   import rob_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reorder_buffer_if rif ();
   reorder_buffer dut (.clk(clk), .rst(rst), .rob(rif));

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   typedef struct {
      logic       rst;
      logic       av;
      logic [7:0] aw;
      logic       tx;
      logic [3:0] id;
      logic [7:0] fl;
      logic [7:0] wb;
      logic [7:0] val;
      logic       e_ready;
      logic [3:0] e_arobid;
      logic [4:0] e_count;
      logic       e_cv;
      logic [3:0] e_crobid;
      logic [7:0] e_cwbs;
      logic [7:0] e_cval;
   } vec_t;
   vec_t vt[$];

   // Reference model: program-order queue of live ids plus per-id contents.
   int         live[$];
   bit         mbusy [16];
   bit         mdone [16];
   logic [7:0] mwbs [16];
   logic [7:0] mflags [16];
   logic [7:0] mval [16];
   int         mtail;
   bit         e_cv, e_flush, e_perr;
   int         e_crobid;
   logic [7:0] e_cwbs, e_cflags, e_cval, e_redirect;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic av, input logic [7:0] aw, input logic tx,
                        input logic [3:0] id, input logic [7:0] fl, input logic [7:0] wb,
                        input logic [7:0] val);
      rif.alloc_valid  = av;
      rif.alloc_wbs    = aw;
      rif.rob_transmit = tx;
      rif.robid        = id;
      rif.flags        = fl;
      rif.wbs          = wb;
      rif.value        = val;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 8'(i), 1'b0, 4'h0, 8'h00, 8'h00, 8'h00);
         tick();
      end
      idle();
   endtask

   function automatic vec_t mk(input logic r, input logic av, input logic [7:0] aw,
                               input logic tx, input logic [3:0] id, input logic [7:0] wb,
                               input logic [7:0] val, input logic er, input logic [3:0] ear,
                               input logic [4:0] ec, input logic ecv, input logic [3:0] ecr,
                               input logic [7:0] ecw, input logic [7:0] ecval);
      vec_t v;
      v.rst = r; v.av = av; v.aw = aw; v.tx = tx; v.id = id; v.fl = 8'h00; v.wb = wb;
      v.val = val; v.e_ready = er; v.e_arobid = ear; v.e_count = ec; v.e_cv = ecv;
      v.e_crobid = ecr; v.e_cwbs = ecw; v.e_cval = ecval;
      return v;
   endfunction

   task automatic model_reset();
      live.delete();
      for (int i = 0; i < 16; i++) begin
         mbusy[i] = 1'b0; mdone[i] = 1'b0;
      end
      mtail = 0;
      e_cv = 1'b0; e_flush = 1'b0; e_perr = 1'b0; e_crobid = 0;
      e_cwbs = '0; e_cflags = '0; e_cval = '0; e_redirect = '0;
   endtask

   function automatic bit model_ready();
      if (live.size() >= 16) return 1'b0;
      if (live.size() > 0 && mdone[live[0]] && mflags[live[0]][5]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit r, input bit av, input logic [7:0] aw, input bit tx,
                             input int id, input logic [7:0] fl, input logic [7:0] wb,
                             input logic [7:0] val);
      bit ready, ret, tkn;
      int h;
      if (r) begin
         model_reset();
         return;
      end
      ready = model_ready();
      ret   = live.size() > 0 && mdone[live[0]];
      tkn   = ret && mflags[live[0]][5];
      if (tx && !tkn) begin
         if (mbusy[id] && !mdone[id]) begin
            mdone[id] = 1'b1; mflags[id] = fl; mwbs[id] = wb; mval[id] = val;
         end else begin
            e_perr = 1'b1;
         end
      end
      e_cv    = ret;
      e_flush = tkn;
      if (ret) begin
         h = live.pop_front();
         e_crobid = h; e_cwbs = mwbs[h]; e_cflags = mflags[h]; e_cval = mval[h];
         mbusy[h] = 1'b0; mdone[h] = 1'b0;
         if (tkn) begin
            e_redirect = mval[h];
            model_reset_entries();
         end
      end
      if (av && ready) begin
         live.push_back(mtail);
         mbusy[mtail] = 1'b1; mdone[mtail] = 1'b0; mwbs[mtail] = aw;
         mflags[mtail] = '0; mval[mtail] = '0;
         mtail = (mtail + 1) % 16;
      end
   endtask

   task automatic model_reset_entries();
      live.delete();
      for (int i = 0; i < 16; i++) begin
         mbusy[i] = 1'b0; mdone[i] = 1'b0;
      end
      mtail = 0;
   endtask

   initial begin
      idle();
      tick();
      do_reset();

      // Reset state, sampled with idle inputs
      @(negedge clk);
      check("rst_alloc_ready", 32'(rif.alloc_ready), 32'd1);
      check("rst_alloc_robid", 32'(rif.alloc_robid), 32'd0);
      check("rst_count", 32'(rif.count), 32'd0);
      check("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
      check("rst_flush", 32'(rif.flush), 32'd0);
      check("rst_perr", 32'(rif.protocol_err), 32'd0);
      check("rst_commit_value", 32'(rif.commit_value), 32'd0);
      check("rst_redirect", 32'(rif.redirect_pc), 32'd0);
      tick();

      // Single alloc/complete/commit, then out-of-order completion retiring in order
      vt.push_back(mk(0, 1, 8'h03, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h70, 8'h2A, 1, 1, 1, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 8'h70, 8'h2A));
      vt.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 1, 8'h12, 0, 0, 8'h00, 8'h00, 1, 2, 2, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 1, 2, 8'h72, 8'hC2, 1, 3, 3, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 1, 1, 8'h71, 8'hC1, 1, 3, 3, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h70, 8'hC0, 1, 3, 3, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 3, 3, 0, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 3, 2, 1, 0, 8'h70, 8'hC0));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 3, 1, 1, 1, 8'h71, 8'hC1));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 3, 0, 1, 2, 8'h72, 8'hC2));
      vt.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 3, 0, 0, 0, 8'h00, 8'h00));
      foreach (vt[i]) begin
         rst = vt[i].rst;
         drive(vt[i].av, vt[i].aw, vt[i].tx, vt[i].id, vt[i].fl, vt[i].wb, vt[i].val);
         @(negedge clk);
         check($sformatf("vec%0d_ready", i), 32'(rif.alloc_ready), 32'(vt[i].e_ready));
         check($sformatf("vec%0d_arobid", i), 32'(rif.alloc_robid), 32'(vt[i].e_arobid));
         check($sformatf("vec%0d_count", i), 32'(rif.count), 32'(vt[i].e_count));
         check($sformatf("vec%0d_cv", i), 32'(rif.commit_valid), 32'(vt[i].e_cv));
         check($sformatf("vec%0d_flush", i), 32'(rif.flush), 32'd0);
         if (vt[i].e_cv) begin
            check($sformatf("vec%0d_crobid", i), 32'(rif.commit_robid), 32'(vt[i].e_crobid));
            check($sformatf("vec%0d_cwbs", i), 32'(rif.commit_wbs), 32'(vt[i].e_cwbs));
            check($sformatf("vec%0d_cval", i), 32'(rif.commit_value), 32'(vt[i].e_cval));
         end
         tick();
      end
      rst = 1'b0;

      // Full buffer: retire with alloc_valid held does not allocate; tail wraps to 0
      do_reset();
      alloc_n(16);
      @(negedge clk);
      check("full_ready", 32'(rif.alloc_ready), 32'd0);
      check("full_count", 32'(rif.count), 32'd16);
      tick();
      drive(1'b1, 8'hEE, 1'b1, 4'd0, 8'h00, 8'h40, 8'h55);
      tick();
      drive(1'b1, 8'hEE, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      check("full_retire_ready", 32'(rif.alloc_ready), 32'd0);
      tick();
      idle();
      @(negedge clk);
      check("full_after_count", 32'(rif.count), 32'd15);
      check("full_after_cv", 32'(rif.commit_valid), 32'd1);
      check("full_after_cval", 32'(rif.commit_value), 32'h55);
      check("full_after_arobid", 32'(rif.alloc_robid), 32'd0);
      check("full_after_ready", 32'(rif.alloc_ready), 32'd1);

      // Taken branch at head flushes; a write in the flush cycle is dropped silently
      do_reset();
      alloc_n(4);
      drive(1'b0, 8'h00, 1'b1, 4'd1, 8'h00, 8'h01, 8'h11);
      tick();
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h20, 8'h02, 8'h80);
      tick();
      drive(1'b1, 8'h99, 1'b1, 4'd2, 8'h00, 8'h03, 8'h33);
      @(negedge clk);
      check("br_hold_ready", 32'(rif.alloc_ready), 32'd0);
      check("br_pre_flush", 32'(rif.flush), 32'd0);
      tick();
      idle();
      @(negedge clk);
      check("br_flush", 32'(rif.flush), 32'd1);
      check("br_cv", 32'(rif.commit_valid), 32'd1);
      check("br_crobid", 32'(rif.commit_robid), 32'd0);
      check("br_redirect", 32'(rif.redirect_pc), 32'h80);
      check("br_count", 32'(rif.count), 32'd0);
      check("br_arobid", 32'(rif.alloc_robid), 32'd0);
      check("br_perr", 32'(rif.protocol_err), 32'd0);
      tick();
      @(negedge clk);
      check("br_flush_pulse", 32'(rif.flush), 32'd0);
      check("br_cv_pulse", 32'(rif.commit_valid), 32'd0);
      tick();

      // Write to unallocated entry: sticky error until reset
      do_reset();
      drive(1'b0, 8'h00, 1'b1, 4'd5, 8'h00, 8'h00, 8'h77);
      tick();
      idle();
      @(negedge clk);
      check("perr_set", 32'(rif.protocol_err), 32'd1);
      check("perr_no_alloc", 32'(rif.count), 32'd0);
      tick(); tick(); tick();
      @(negedge clk);
      check("perr_sticky", 32'(rif.protocol_err), 32'd1);
      do_reset();
      @(negedge clk);
      check("perr_cleared", 32'(rif.protocol_err), 32'd0);
      tick();

      // Second write to an already-done entry
      alloc_n(1);
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h00, 8'h00, 8'h01);
      tick();
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h00, 8'h00, 8'h02);
      tick();
      idle();
      @(negedge clk);
      check("perr_done_write", 32'(rif.protocol_err), 32'd1);
      check("perr_done_cval", 32'(rif.commit_value), 32'h01);
      tick();

      // Reset wins over live entries, allocation, write and retire
      do_reset();
      alloc_n(6);
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h00, 8'h00, 8'h44);
      tick();
      rst = 1'b1;
      drive(1'b1, 8'h12, 1'b1, 4'd1, 8'h00, 8'h00, 8'h45);
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("rstmid_count", 32'(rif.count), 32'd0);
      check("rstmid_cv", 32'(rif.commit_valid), 32'd0);
      check("rstmid_ready", 32'(rif.alloc_ready), 32'd1);
      check("rstmid_arobid", 32'(rif.alloc_robid), 32'd0);
      tick();

      // Random traffic against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit         r_rst, r_av, r_tx;
         int         r_id;
         logic [7:0] r_aw, r_fl, r_wb, r_val;
         int         pend[$];
         r_rst = ($urandom_range(0, 199) == 0);
         r_av  = ($urandom_range(0, 4) < 3);
         r_aw  = 8'($urandom);
         r_wb  = 8'($urandom);
         r_val = 8'($urandom);
         r_fl  = 8'($urandom) & 8'hDF;
         if ($urandom_range(0, 11) == 0) r_fl = r_fl | 8'h20;
         foreach (live[k]) if (!mdone[live[k]]) pend.push_back(live[k]);
         r_tx = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 59) == 0 || pend.size() == 0) r_id = $urandom_range(0, 15);
         else r_id = pend[$urandom_range(0, pend.size() - 1)];
         if (pend.size() == 0 && $urandom_range(0, 9) != 0) r_tx = 1'b0;

         rst = r_rst;
         drive(r_av, r_aw, r_tx, 4'(r_id), r_fl, r_wb, r_val);
         @(negedge clk);
         check("rnd_ready", 32'(rif.alloc_ready), 32'(model_ready()));
         check("rnd_arobid", 32'(rif.alloc_robid), 32'(mtail));
         check("rnd_count", 32'(rif.count), 32'(live.size()));
         check("rnd_cv", 32'(rif.commit_valid), 32'(e_cv));
         check("rnd_flush", 32'(rif.flush), 32'(e_flush));
         check("rnd_perr", 32'(rif.protocol_err), 32'(e_perr));
         if (e_cv) begin
            check("rnd_crobid", 32'(rif.commit_robid), 32'(e_crobid));
            check("rnd_cwbs", 32'(rif.commit_wbs), 32'(e_cwbs));
            check("rnd_cflags", 32'(rif.commit_flags), 32'(e_cflags));
            check("rnd_cval", 32'(rif.commit_value), 32'(e_cval));
         end
         if (e_flush) check("rnd_redirect", 32'(rif.redirect_pc), 32'(e_redirect));
         model_step(r_rst, r_av, r_aw, r_tx, r_id, r_fl, r_wb, r_val);
         tick();
      end
      rst = 1'b0;
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
